hex_display_scanner: RTL and testbench

HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

---
 rtl/hex_display_scanner_pkg.sv | 47 ++++
 rtl/hex_display_scanner_decode.sv | 11 +
 rtl/hex_display_scanner.sv | 160 ++++++++++++++++
 tb/tb_hex_display_scanner.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_scanner_pkg.sv
// Shared constants, segment table and parameter checks for the multiplexed hex display scanner.
// Segment vectors are active-low, ordered gfedcba.
package hex_display_scanner_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam int unsigned MIN_DIGITS       = 1;
    localparam int unsigned MAX_DIGITS       = 8;
    localparam int unsigned MIN_SCAN_DIV     = 2;
    localparam int unsigned MIN_BLINK_FRAMES = 1;

    // Element 15 (F) first, element 0 last.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic bit params_ok(input int unsigned num_digits,
                                     input int unsigned scan_div,
                                     input int unsigned blink_frames);
        return (num_digits >= MIN_DIGITS) && (num_digits <= MAX_DIGITS) &&
               (scan_div >= MIN_SCAN_DIV) && (blink_frames >= MIN_BLINK_FRAMES);
    endfunction

    // Counter width that still works for a range of one.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_display_scanner_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex7seg_decode
    import hex_display_scanner_pkg::*;
(
    input  nibble_t nibble,
    output seg_t    seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed hex display scanner: prescaled digit scan, frame-synchronous value commit with
// load/ack handshake, leading-zero blanking and whole-display blinking.
module hex_display_scanner
    import hex_display_scanner_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic                    ready,
    output logic                    ack,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en
);

    if (!params_ok(NUM_DIGITS, SCAN_DIV, BLINK_FRAMES)) begin : g_bad_params
        $error("hex_display_scanner: parameter out of range");
    end

    localparam int unsigned CNT_W = width_for(SCAN_DIV);
    localparam int unsigned IDX_W = width_for(NUM_DIGITS);
    localparam int unsigned FRM_W = width_for(BLINK_FRAMES);
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [FRM_W-1:0]      frm_q;
    logic                  phase_q;
    logic                  pending_q;
    logic [VAL_W-1:0]      staging_q;
    logic [VAL_W-1:0]      display_q;
    logic                  ack_q;
    seg_t                  seg_q;
    logic [NUM_DIGITS-1:0] dig_en_q;

    logic                  tick;
    logic                  frame_end;
    logic                  commit;
    logic [VAL_W-1:0]      staging_nxt;

    nibble_t               cur_nibble;
    logic                  upper_zero;
    logic [NUM_DIGITS-1:0] onehot_low;
    logic                  lz_blank;
    logic                  blink_off;
    seg_t                  dec_seg;
    seg_t                  seg_d;
    logic [NUM_DIGITS-1:0] dig_en_d;

    assign tick      = (cnt_q == CNT_LAST);
    assign frame_end = tick && (idx_q == IDX_LAST);
    assign commit    = frame_end && pending_q;

    // A load landing on the commit cycle is merged into the commit.
    assign staging_nxt = load ? value : staging_q;

    // Scan timing: prescaler, digit index and blink phase.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            frm_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
            if (tick) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
            if (frame_end) begin
                if (frm_q == FRM_LAST) begin
                    frm_q   <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    frm_q <= frm_q + FRM_W'(1);
                end
            end
        end
    end

    // Load handshake; display only changes at a frame boundary so a frame never tears.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pending_q <= 1'b0;
            staging_q <= '0;
            display_q <= '0;
            ack_q     <= 1'b0;
        end else begin
            if (load) begin
                staging_q <= value;
            end
            if (commit) begin
                display_q <= staging_nxt;
                pending_q <= 1'b0;
            end else if (load) begin
                pending_q <= 1'b1;
            end
            ack_q <= commit;
        end
    end

    always_comb begin
        cur_nibble = '0;
        upper_zero = 1'b1;
        onehot_low = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nibble    = display_q[4*i +: 4];
                onehot_low[i] = 1'b0;
            end
            if ((IDX_W'(i) >= idx_q) && (display_q[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    hex7seg_decode u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    assign lz_blank  = blank_lz && (idx_q != '0) && upper_zero;
    assign blink_off = blink_en && phase_q;

    always_comb begin
        seg_d    = dec_seg;
        dig_en_d = onehot_low;
        if (blink_off) begin
            seg_d    = SEG_BLANK;
            dig_en_d = '1;
        end else if (lz_blank) begin
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            seg_q    <= SEG_BLANK;
            dig_en_q <= '1;
        end else begin
            seg_q    <= seg_d;
            dig_en_q <= dig_en_d;
        end
    end

    assign ready  = ~pending_q;
    assign ack    = ack_q;
    assign seg    = seg_q;
    assign dig_en = dig_en_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: directed scenarios plus random loads, every cycle checked
// against a timeline model derived from the edge count since reset release.
module tb_hex_display_scanner;

    localparam int unsigned ND    = 4;
    localparam int unsigned SD    = 4;
    localparam int unsigned BF    = 2;
    localparam int          FRAME = ND * SD;
    localparam int          HALF  = FRAME * BF;

    logic          clock;
    logic          resetn;
    logic          load;
    logic [15:0]   value;
    logic          blank_lz;
    logic          blink_en;
    logic          ready;
    logic          ack;
    logic [6:0]    seg;
    logic [3:0]    dig_en;

    hex_display_scanner #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .ready    (ready),
        .ack      (ack),
        .seg      (seg),
        .dig_en   (dig_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int tests = 0;
    int fails = 0;

    // Model state: edges since release, committed/staged value and pending flag.
    int          mk;
    logic [15:0] m_shown;
    logic [15:0] m_staged;
    bit          m_pending;
    logic [6:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_ack;

    int          ack_cnt;
    int          off_cnt;
    int          run_len;
    int          max_run;
    logic [6:0]  cap [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mk        = 0;
        m_shown   = '0;
        m_staged  = '0;
        m_pending = 1'b0;
        e_ack     = 1'b0;
    endtask

    // Outputs after an edge show the digit selected before it; commit occurs at frame end.
    task automatic model_edge(input logic ld, input logic [15:0] v);
        int         idx;
        int         ph;
        logic [3:0] nib;
        idx = (mk / SD) % ND;
        ph  = (mk / HALF) % 2;
        if (blink_en && ph == 1) begin
            e_seg = 7'h7F;
            e_dig = 4'hF;
        end else begin
            e_dig = ~(4'b0001 << idx);
            nib   = 4'(m_shown >> (4 * idx));
            if (blank_lz && idx > 0 && (m_shown >> (4 * idx)) == 16'h0) e_seg = 7'h7F;
            else e_seg = hex_tbl[nib];
        end
        e_ack = 1'b0;
        if ((mk % FRAME) == FRAME - 1 && m_pending) begin
            m_shown   = ld ? v : m_staged;
            m_staged  = m_shown;
            m_pending = 1'b0;
            e_ack     = 1'b1;
        end else if (ld) begin
            m_staged  = v;
            m_pending = 1'b1;
        end
        mk++;
    endtask

    task automatic step(input logic ld, input logic [15:0] v);
        load  = ld;
        value = v;
        @(posedge clock);
        model_edge(ld, v);
        #1;
        chk("seg", {25'd0, seg}, {25'd0, e_seg});
        chk("dig_en", {28'd0, dig_en}, {28'd0, e_dig});
        chk("ack", {31'd0, ack}, {31'd0, e_ack});
        chk("ready", {31'd0, ready}, {31'd0, ~m_pending});
        if (ack === 1'b1) ack_cnt++;
        if (dig_en === 4'hF) begin
            off_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        for (int i = 0; i < 4; i++) if (dig_en === ~(4'b0001 << i)) cap[i] = seg;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, value);
    endtask

    task automatic align(input int modulus, input int target);
        for (int i = 0; i < modulus && (mk % modulus) != target; i++) step(1'b0, value);
    endtask

    task automatic do_reset();
        #2 resetn = 1'b0;
        load = 1'b0;
        #1;
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dig_en", {28'd0, dig_en}, 32'hF);
        chk("rst_ack", {31'd0, ack}, 32'h0);
        chk("rst_ready", {31'd0, ready}, 32'h1);
        @(posedge clock);
        #1;
        chk("rst_hold_seg", {25'd0, seg}, 32'h7F);
        chk("rst_hold_dig_en", {28'd0, dig_en}, 32'hF);
        @(negedge clock);
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [15:0] rv;
        resetn   = 1'b1;
        load     = 1'b0;
        value    = '0;
        blank_lz = 1'b0;
        blink_en = 1'b0;
        ack_cnt  = 0;
        off_cnt  = 0;
        run_len  = 0;
        max_run  = 0;
        model_reset();

        // Reset then idle scan.
        do_reset();
        step(1'b0, 16'h0);
        chk("idle_d0_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        chk("idle_d0_en", {28'd0, dig_en}, {28'd0, 4'b1110});
        run(4);
        chk("idle_d1_en", {28'd0, dig_en}, {28'd0, 4'b1101});
        run(4);
        chk("idle_d2_en", {28'd0, dig_en}, {28'd0, 4'b1011});
        run(4);
        chk("idle_d3_en", {28'd0, dig_en}, {28'd0, 4'b0111});
        run(4);
        chk("idle_wrap_en", {28'd0, dig_en}, {28'd0, 4'b1110});

        // Single load mid-frame.
        align(FRAME, 5);
        step(1'b1, 16'h1A3F);
        chk("ready_after_load", {31'd0, ready}, 32'h0);
        ack_cnt = 0;
        run(40);
        chk("one_ack_1a3f", ack_cnt, 1);
        chk("ready_after_ack", {31'd0, ready}, 32'h1);
        run(16);
        chk("show_d0_F", {25'd0, cap[0]}, {25'd0, 7'b0001110});
        chk("show_d1_3", {25'd0, cap[1]}, {25'd0, 7'b0110000});
        chk("show_d2_A", {25'd0, cap[2]}, {25'd0, 7'b0001000});
        chk("show_d3_1", {25'd0, cap[3]}, {25'd0, 7'b1111001});

        // Two loads in one frame merge into one commit.
        align(FRAME, 2);
        ack_cnt = 0;
        step(1'b1, 16'h0001);
        run(3);
        step(1'b1, 16'h0002);
        run(40);
        chk("one_ack_merged", ack_cnt, 1);
        run(16);
        chk("merged_d0", {25'd0, cap[0]}, {25'd0, 7'b0100100});
        chk("merged_d1", {25'd0, cap[1]}, {25'd0, 7'b1000000});
        chk("merged_d3", {25'd0, cap[3]}, {25'd0, 7'b1000000});

        // Leading-zero blanking.
        blank_lz = 1'b1;
        step(1'b1, 16'h0000);
        run(40);
        chk("lz0_d0", {25'd0, cap[0]}, {25'd0, 7'b1000000});
        chk("lz0_d1", {25'd0, cap[1]}, 32'h7F);
        chk("lz0_d2", {25'd0, cap[2]}, 32'h7F);
        chk("lz0_d3", {25'd0, cap[3]}, 32'h7F);
        step(1'b1, 16'h0050);
        run(40);
        chk("lz50_d0", {25'd0, cap[0]}, {25'd0, 7'b1000000});
        chk("lz50_d1", {25'd0, cap[1]}, {25'd0, 7'b0010010});
        chk("lz50_d2", {25'd0, cap[2]}, 32'h7F);
        chk("lz50_d3", {25'd0, cap[3]}, 32'h7F);
        blank_lz = 1'b0;

        // Blinking: equal visible/blank halves with whole-frame granularity.
        blink_en = 1'b1;
        align(2 * HALF, 0);
        off_cnt = 0;
        run_len = 0;
        max_run = 0;
        run(4 * HALF);
        chk("blink_off_cycles", off_cnt, 2 * HALF);
        chk("blink_max_run", max_run, HALF);
        blink_en = 1'b0;

        // Random loads and mode changes.
        for (int r = 0; r < 640; r++) begin
            if (r % 40 == 0) begin
                blank_lz = 1'($urandom_range(0, 1));
                blink_en = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 7) == 0) begin
                rv = 16'($urandom);
                rv = rv >> (4 * $urandom_range(0, 4));
                step(1'b1, rv);
            end else begin
                step(1'b0, value);
            end
        end
        blank_lz = 1'b0;
        blink_en = 1'b0;

        // Reset while an update is pending.
        align(FRAME, 4);
        step(1'b1, 16'hBEEF);
        chk("pending_before_reset", {31'd0, ready}, 32'h0);
        do_reset();
        ack_cnt = 0;
        run(3 * FRAME);
        chk("no_ack_after_reset", ack_cnt, 0);
        chk("ready_after_reset", {31'd0, ready}, 32'h1);
        chk("discarded_d3", {25'd0, cap[3]}, {25'd0, 7'b1000000});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
